dmem_access_scheduler: RTL and testbench

Round-robin scheduler that shares the dual-port data memory between `NCORES` cores. It latches no request data; it selects up to two requesters per cycle, drives memory ports A and B, returns per-core grants, and delivers read data one cycle later. It owns the round-robin pointer and instantiates `dual_issue_arbiter` for selection. It sits between the core load/store units and the shared dmem macro.

---
 rtl/dmem_access_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_dmem_access_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_scheduler.sv
// dmem_access_scheduler: round-robin dual-issue scheduler for the shared data
// memory, plus the dual_issue_arbiter that picks up to two requesters per cycle.

`ifndef NCORES
`define NCORES 4
`endif
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 12
`endif

module dual_issue_arbiter #(
    parameter int N  = 4,
    parameter int AW = 12,
    parameter int PW = $clog2(N)
) (
    input  logic [PW-1:0]   ptr_i,
    input  logic [N-1:0]    valid_i,
    input  logic [N*AW-1:0] addr_packed_i,
    output logic [PW-1:0]   sel_a_o,
    output logic [PW-1:0]   sel_b_o,
    output logic            valid_a_o,
    output logic            valid_b_o
);
    logic          found_b;
    logic [AW-3:0] word_a;
    logic [AW-3:0] word_b;

    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        return (s >= N) ? s - N : s;
    endfunction

    // Scan requesters circularly from the pointer: first hit is A, second is B.
    always_comb begin
        sel_a_o   = '0;
        sel_b_o   = '0;
        valid_a_o = 1'b0;
        found_b   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (valid_i[wrap_idx(int'(ptr_i), k)]) begin
                if (!valid_a_o) begin
                    valid_a_o = 1'b1;
                    sel_a_o   = PW'(wrap_idx(int'(ptr_i), k));
                end else if (!found_b) begin
                    found_b = 1'b1;
                    sel_b_o = PW'(wrap_idx(int'(ptr_i), k));
                end
            end
        end
    end

    // Same-word pairs are never co-issued; this also keeps read/write to one word ordered.
    always_comb begin
        word_a    = addr_packed_i[int'(sel_a_o)*AW+2 +: AW-2];
        word_b    = addr_packed_i[int'(sel_b_o)*AW+2 +: AW-2];
        valid_b_o = found_b && (word_a != word_b);
    end
endmodule

module dmem_access_scheduler #(
    parameter int NCORES     = `NCORES,
    parameter int ADDR_WIDTH = `DMEM_ADDRW
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NCORES-1:0]              req_valid_i,
    input  logic [NCORES-1:0]              req_we_i,
    input  logic [NCORES*ADDR_WIDTH-1:0]   req_addr_packed_i,
    input  logic [NCORES*32-1:0]           req_wdata_packed_i,
    input  logic [NCORES*4-1:0]            req_wstrb_packed_i,
    output logic [NCORES-1:0]              gnt_o,
    output logic [NCORES-1:0]              rsp_valid_o,
    output logic [NCORES*32-1:0]           rsp_rdata_packed_o,
    output logic                           mem_en_a_o,
    output logic                           mem_en_b_o,
    output logic                           mem_we_a_o,
    output logic                           mem_we_b_o,
    output logic [ADDR_WIDTH-3:0]          mem_addr_a_o,
    output logic [ADDR_WIDTH-3:0]          mem_addr_b_o,
    output logic [31:0]                    mem_wdata_a_o,
    output logic [31:0]                    mem_wdata_b_o,
    output logic [3:0]                     mem_wstrb_a_o,
    output logic [3:0]                     mem_wstrb_b_o,
    input  logic [31:0]                    mem_rdata_a_i,
    input  logic [31:0]                    mem_rdata_b_i
);
    localparam int PW = $clog2(NCORES);

    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] sel_a, sel_b, last;
    logic          valid_a, valid_b;
    logic          vld_a_q, vld_b_q, rd_a_q, rd_b_q;
    logic [PW-1:0] core_a_q, core_b_q;

    dual_issue_arbiter #(
        .N  (NCORES),
        .AW (ADDR_WIDTH),
        .PW (PW)
    ) u_arb (
        .ptr_i         (rr_ptr_q),
        .valid_i       (req_valid_i),
        .addr_packed_i (req_addr_packed_i),
        .sel_a_o       (sel_a),
        .sel_b_o       (sel_b),
        .valid_a_o     (valid_a),
        .valid_b_o     (valid_b)
    );

    // Pointer moves just past the last core granted; NCORES need not be a power of two.
    always_comb begin
        last     = valid_b ? sel_b : sel_a;
        rr_ptr_d = rr_ptr_q;
        if (valid_a) begin
            rr_ptr_d = (int'(last) == NCORES - 1) ? '0 : last + PW'(1);
        end
    end

    // Pointer and response pipeline; reset drops anything granted in the reset cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            vld_a_q  <= 1'b0;
            vld_b_q  <= 1'b0;
            core_a_q <= '0;
            core_b_q <= '0;
            rd_a_q   <= 1'b0;
            rd_b_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_a_q  <= valid_a;
            vld_b_q  <= valid_b;
            core_a_q <= sel_a;
            core_b_q <= sel_b;
            rd_a_q   <= !req_we_i[sel_a];
            rd_b_q   <= !req_we_i[sel_b];
        end
    end

    // Drive memory ports and grants from the selected cores; everything idles in reset.
    always_comb begin
        gnt_o         = '0;
        mem_en_a_o    = 1'b0;
        mem_we_a_o    = 1'b0;
        mem_addr_a_o  = '0;
        mem_wdata_a_o = '0;
        mem_wstrb_a_o = '0;
        mem_en_b_o    = 1'b0;
        mem_we_b_o    = 1'b0;
        mem_addr_b_o  = '0;
        mem_wdata_b_o = '0;
        mem_wstrb_b_o = '0;
        if (rst_ni && valid_a) begin
            gnt_o[sel_a]  = 1'b1;
            mem_en_a_o    = 1'b1;
            mem_we_a_o    = req_we_i[sel_a];
            mem_addr_a_o  = req_addr_packed_i[int'(sel_a)*ADDR_WIDTH+2 +: ADDR_WIDTH-2];
            mem_wdata_a_o = req_wdata_packed_i[int'(sel_a)*32 +: 32];
            mem_wstrb_a_o = req_wstrb_packed_i[int'(sel_a)*4 +: 4];
        end
        if (rst_ni && valid_b) begin
            gnt_o[sel_b]  = 1'b1;
            mem_en_b_o    = 1'b1;
            mem_we_b_o    = req_we_i[sel_b];
            mem_addr_b_o  = req_addr_packed_i[int'(sel_b)*ADDR_WIDTH+2 +: ADDR_WIDTH-2];
            mem_wdata_b_o = req_wdata_packed_i[int'(sel_b)*32 +: 32];
            mem_wstrb_b_o = req_wstrb_packed_i[int'(sel_b)*4 +: 4];
        end
    end

    // Route last cycle's port responses back to the owning cores; writes return zero data.
    always_comb begin
        rsp_valid_o        = '0;
        rsp_rdata_packed_o = '0;
        if (vld_a_q) begin
            rsp_valid_o[core_a_q] = 1'b1;
            if (rd_a_q) rsp_rdata_packed_o[int'(core_a_q)*32 +: 32] = mem_rdata_a_i;
        end
        if (vld_b_q) begin
            rsp_valid_o[core_b_q] = 1'b1;
            if (rd_b_q) rsp_rdata_packed_o[int'(core_b_q)*32 +: 32] = mem_rdata_b_i;
        end
    end
endmodule

// File: tb/tb_dmem_access_scheduler.sv
// Directed bench for dmem_access_scheduler: a 4-core instance for most
// scenarios and a 3-core instance for the non-power-of-two wrap case.

module tb_dmem_access_scheduler;
    localparam int AW = 12;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    // 4-core instance
    logic [3:0]      req_valid4, req_we4, gnt4, rsp_valid4;
    logic [4*AW-1:0] req_addr4;
    logic [127:0]    req_wdata4, rsp_rdata4;
    logic [15:0]     req_wstrb4;
    logic            en_a4, en_b4, we_a4, we_b4;
    logic [AW-3:0]   addr_a4, addr_b4;
    logic [31:0]     wdata_a4, wdata_b4, rdata_a4, rdata_b4;
    logic [3:0]      wstrb_a4, wstrb_b4;

    // 3-core instance
    logic [2:0]      req_valid3, req_we3, gnt3, rsp_valid3;
    logic [3*AW-1:0] req_addr3;
    logic [95:0]     req_wdata3, rsp_rdata3;
    logic [11:0]     req_wstrb3;
    logic            en_a3, en_b3, we_a3, we_b3;
    logic [AW-3:0]   addr_a3, addr_b3;
    logic [31:0]     wdata_a3, wdata_b3, rdata_a3, rdata_b3;
    logic [3:0]      wstrb_a3, wstrb_b3;

    dmem_access_scheduler #(.NCORES(4), .ADDR_WIDTH(AW)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid4), .req_we_i(req_we4),
        .req_addr_packed_i(req_addr4), .req_wdata_packed_i(req_wdata4),
        .req_wstrb_packed_i(req_wstrb4),
        .gnt_o(gnt4), .rsp_valid_o(rsp_valid4), .rsp_rdata_packed_o(rsp_rdata4),
        .mem_en_a_o(en_a4), .mem_en_b_o(en_b4), .mem_we_a_o(we_a4), .mem_we_b_o(we_b4),
        .mem_addr_a_o(addr_a4), .mem_addr_b_o(addr_b4),
        .mem_wdata_a_o(wdata_a4), .mem_wdata_b_o(wdata_b4),
        .mem_wstrb_a_o(wstrb_a4), .mem_wstrb_b_o(wstrb_b4),
        .mem_rdata_a_i(rdata_a4), .mem_rdata_b_i(rdata_b4)
    );

    dmem_access_scheduler #(.NCORES(3), .ADDR_WIDTH(AW)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid3), .req_we_i(req_we3),
        .req_addr_packed_i(req_addr3), .req_wdata_packed_i(req_wdata3),
        .req_wstrb_packed_i(req_wstrb3),
        .gnt_o(gnt3), .rsp_valid_o(rsp_valid3), .rsp_rdata_packed_o(rsp_rdata3),
        .mem_en_a_o(en_a3), .mem_en_b_o(en_b3), .mem_we_a_o(we_a3), .mem_we_b_o(we_b3),
        .mem_addr_a_o(addr_a3), .mem_addr_b_o(addr_b3),
        .mem_wdata_a_o(wdata_a3), .mem_wdata_b_o(wdata_b3),
        .mem_wstrb_a_o(wstrb_a3), .mem_wstrb_b_o(wstrb_b3),
        .mem_rdata_a_i(rdata_a3), .mem_rdata_b_i(rdata_b3)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req4(input int c, input logic v, input logic we,
                        input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] ws);
        req_valid4[c]          = v;
        req_we4[c]             = we;
        req_addr4[c*AW +: AW]  = a;
        req_wdata4[c*32 +: 32] = wd;
        req_wstrb4[c*4 +: 4]   = ws;
    endtask

    task automatic req3(input int c, input logic v, input logic [AW-1:0] a);
        req_valid3[c]         = v;
        req_addr3[c*AW +: AW] = a;
    endtask

    initial begin
        rst_ni     = 1'b0;
        req_valid4 = '0; req_we4 = '0; req_addr4 = '0; req_wdata4 = '0; req_wstrb4 = '0;
        req_valid3 = '0; req_we3 = '0; req_addr3 = '0; req_wdata3 = '0; req_wstrb3 = '0;
        rdata_a4 = '0; rdata_b4 = '0; rdata_a3 = '0; rdata_b3 = '0;

        // Reset held 3 cycles with all four cores requesting distinct words
        for (int i = 0; i < 4; i++) req4(i, 1'b1, 1'b0, AW'(12'h100 + 4*i), 32'h0, 4'hF);
        #1;
        chk("rst_gnt", 128'(gnt4), 128'h0);
        chk("rst_en_a", 128'(en_a4), 128'h0);
        chk("rst_en_b", 128'(en_b4), 128'h0);
        tick(); tick(); tick();
        chk("rst_rsp_valid", 128'(rsp_valid4), 128'h0);
        chk("rst_rsp_rdata", rsp_rdata4, 128'h0);
        chk("rst_gnt_held", 128'(gnt4), 128'h0);

        // Release: first dual grant to cores 0/1
        rst_ni = 1'b1;
        req4(3, 1'b1, 1'b1, 12'h10C, 32'hA5A5_5A5A, 4'h6);
        #1;
        chk("fair0_gnt", 128'(gnt4), 128'h3);
        chk("fair0_addr_a", 128'(addr_a4), 128'h040);
        chk("fair0_addr_b", 128'(addr_b4), 128'h041);
        tick();
        chk("fair0_ptr", 128'(dut4.rr_ptr_q), 128'h2);
        rdata_a4 = 32'h1111_0000; rdata_b4 = 32'h2222_0000;
        #1;
        chk("fair1_gnt", 128'(gnt4), 128'hC);
        chk("fair1_we_a", 128'(we_a4), 128'h0);
        chk("fair1_we_b", 128'(we_b4), 128'h1);
        chk("fair1_wdata_b", 128'(wdata_b4), 128'hA5A5_5A5A);
        chk("fair1_wstrb_b", 128'(wstrb_b4), 128'h6);
        chk("fair1_rsp_valid", 128'(rsp_valid4), 128'h3);
        chk("fair1_rsp_rdata", rsp_rdata4, 128'h0000_0000_0000_0000_2222_0000_1111_0000);
        tick();
        rdata_a4 = 32'h3333_0000; rdata_b4 = 32'h4444_0000;
        #1;
        chk("fair2_gnt", 128'(gnt4), 128'h3);
        chk("fair2_rsp_valid", 128'(rsp_valid4), 128'hC);
        chk("fair2_rsp_rdata", rsp_rdata4, 128'h0000_0000_3333_0000_0000_0000_0000_0000);

        // One-cycle reset discards the in-flight 0/1 grant and clears the pointer
        rst_ni = 1'b0;
        tick();
        chk("rst2_rsp_valid", 128'(rsp_valid4), 128'h0);
        chk("rst2_ptr", 128'(dut4.rr_ptr_q), 128'h0);
        rst_ni = 1'b1;
        req_valid4 = '0;
        rdata_a4 = '0; rdata_b4 = '0;

        // Same-word conflict: core0 read 0x40, core1 write 0x42
        req4(0, 1'b1, 1'b0, 12'h040, 32'h0, 4'hF);
        req4(1, 1'b1, 1'b1, 12'h042, 32'hBEEF_0001, 4'hC);
        #1;
        chk("conf0_gnt", 128'(gnt4), 128'h1);
        chk("conf0_en_b", 128'(en_b4), 128'h0);
        chk("conf0_addr_b", 128'(addr_b4), 128'h0);
        chk("conf0_addr_a", 128'(addr_a4), 128'h010);
        tick();
        req_valid4[0] = 1'b0;
        rdata_a4 = 32'hCAFE_0001;
        #1;
        chk("conf1_gnt", 128'(gnt4), 128'h2);
        chk("conf1_we_a", 128'(we_a4), 128'h1);
        chk("conf1_wdata_a", 128'(wdata_a4), 128'hBEEF_0001);
        chk("conf1_rsp_valid", 128'(rsp_valid4), 128'h1);
        chk("conf1_rsp_rdata", rsp_rdata4, 128'hCAFE_0001);
        tick();
        req_valid4 = '0;
        rdata_a4 = '0;

        // Single requester core2 goes on port A, then back-to-back with core3 (ptr=3)
        req4(2, 1'b1, 1'b0, 12'h200, 32'h0, 4'hF);
        #1;
        chk("single_gnt", 128'(gnt4), 128'h4);
        chk("single_en_b", 128'(en_b4), 128'h0);
        tick();
        req4(3, 1'b1, 1'b0, 12'h300, 32'h0, 4'hF);
        #1;
        chk("route_gnt", 128'(gnt4), 128'hC);
        chk("route_addr_a", 128'(addr_a4), 128'h0C0);
        chk("route_addr_b", 128'(addr_b4), 128'h080);
        chk("b2b_rsp_valid", 128'(rsp_valid4), 128'h4);
        tick();
        req_valid4 = '0;
        rdata_a4 = 32'h1234_5678; rdata_b4 = 32'hDEAD_BEEF;
        #1;
        chk("route_rsp_valid", 128'(rsp_valid4), 128'hC);
        chk("route_rsp_rdata", rsp_rdata4, 128'h1234_5678_DEAD_BEEF_0000_0000_0000_0000);
        chk("idle_gnt", 128'(gnt4), 128'h0);
        chk("idle_en_a", 128'(en_a4), 128'h0);
        tick();
        rdata_a4 = '0; rdata_b4 = '0;

        // Reset mid-flight: core1 read granted, then reset taken at the edge
        req4(1, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        #1;
        chk("mid_gnt", 128'(gnt4), 128'h2);
        rst_ni = 1'b0;
        #1;
        chk("mid_gnt_forced", 128'(gnt4), 128'h0);
        tick();
        chk("mid_rsp_valid", 128'(rsp_valid4), 128'h0);
        chk("mid_ptr", 128'(dut4.rr_ptr_q), 128'h0);
        rst_ni = 1'b1;
        req4(2, 1'b1, 1'b0, 12'h200, 32'h0, 4'hF);
        #1;
        chk("mid_after_gnt", 128'(gnt4), 128'h6);
        tick();
        chk("mid_after_rsp", 128'(rsp_valid4), 128'h6);
        req_valid4 = '0;

        // NCORES=3 wrap-around: ptr driven to 2, then cores 2 and 0 request
        req3(1, 1'b1, 12'h010);
        #1;
        chk("w3_single_gnt", 128'(gnt3), 128'h2);
        tick();
        chk("w3_ptr2", 128'(dut3.rr_ptr_q), 128'h2);
        req3(1, 1'b0, 12'h010);
        req3(2, 1'b1, 12'h020);
        req3(0, 1'b1, 12'h034);
        #1;
        chk("w3_gnt", 128'(gnt3), 128'h5);
        chk("w3_addr_a", 128'(addr_a3), 128'h008);
        chk("w3_addr_b", 128'(addr_b3), 128'h00D);
        chk("w3_en_b", 128'(en_b3), 128'h1);
        tick();
        chk("w3_ptr1", 128'(dut3.rr_ptr_q), 128'h1);
        req3(1, 1'b1, 12'h050);
        #1;
        chk("w3_next_gnt", 128'(gnt3), 128'h6);
        tick();
        req_valid3 = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
